// File: rtl/exception_arbiter_pkg.sv
// Shared definitions for the CP0 exception arbiter: state encoding, ExcCode values,
// reset constants and the request-index to ExcCode map.
package exception_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StFlush   = 2'd1,
      StCommit  = 2'd2,
      StHandler = 2'd3
   } state_e;

   localparam logic [4:0] ExcInt  = 5'd0;
   localparam logic [4:0] ExcAdel = 5'd4;
   localparam logic [4:0] ExcAdes = 5'd5;
   localparam logic [4:0] ExcDbe  = 5'd7;
   localparam logic [4:0] ExcSys  = 5'd8;
   localparam logic [4:0] ExcBp   = 5'd9;
   localparam logic [4:0] ExcRi   = 5'd10;
   localparam logic [4:0] ExcOv   = 5'd12;
   localparam logic [4:0] ExcTr   = 5'd13;

   localparam logic [1:0] StateRst = 2'd0;
   localparam logic [4:0] CodeRst  = 5'd0;

   // Request lines beyond the architected eight have no ExcCode; they report Int.
   function automatic logic [4:0] exc_code_map(input int idx);
      logic [4:0] code;
      case (idx)
         0:       code = ExcAdel;
         1:       code = ExcAdes;
         2:       code = ExcSys;
         3:       code = ExcBp;
         4:       code = ExcRi;
         5:       code = ExcOv;
         6:       code = ExcTr;
         7:       code = ExcDbe;
         default: code = ExcInt;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/exception_arbiter_exc_prio_enc.sv
// Combinational priority encoder: lowest set request index wins and is mapped to its ExcCode.
module exc_prio_enc
   import exception_arbiter_pkg::*;
#(
   parameter int unsigned EXC_W = 8
) (
   input  logic [EXC_W-1:0] i_req,
   output logic             o_valid,
   output logic [4:0]       o_code
);

   always_comb begin
      o_valid = 1'b0;
      o_code  = ExcInt;
      // Walk from the top so the lowest index overwrites last.
      for (int i = int'(EXC_W) - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_valid = 1'b1;
            o_code  = exc_code_map(i);
         end
      end
   end

endmodule

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset.
module flopr #(
   parameter int unsigned           WIDTH     = 1,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_q <= RESET_VAL;
      end else begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/flopren.sv
// Register with load enable and synchronous active-high reset.
module flopren #(
   parameter int unsigned           WIDTH     = 1,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_q <= RESET_VAL;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/exception_arbiter.sv
// CP0 exception/interrupt arbiter: flush sequencing, Cause commit, EPC strobe, handler tracking.
// Build option IRQ_SYNC_EN: adds a 2-flop synchronizer on the hardware interrupt lines.
module exception_arbiter
   import exception_arbiter_pkg::*;
#(
   parameter int unsigned EXC_W    = 8,
   parameter int unsigned HW_IRQ_W = 6,
   parameter int unsigned SW_IRQ_W = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [EXC_W-1:0]             exc_req,
   input  logic                         exc_bd,
   input  logic [HW_IRQ_W-1:0]          ip_h_in,
   input  logic [SW_IRQ_W-1:0]          ip_s_in,
   input  logic [HW_IRQ_W+SW_IRQ_W-1:0] int_mask,
   input  logic                         int_en,
   input  logic                         exl,
   input  logic                         eret,
   input  logic                         flush_ack,
   output logic                         flush_req,
   output logic                         exception_abort,
   output logic                         irq_h,
   output logic                         irq_s,
   output logic [HW_IRQ_W-1:0]          ip_h,
   output logic [SW_IRQ_W-1:0]          ip_s,
   output logic [4:0]                   exception_code,
   output logic                         bd_p,
   output logic                         epc_we,
   output logic                         busy
);

   logic [HW_IRQ_W-1:0] w_ip_h;
   logic [HW_IRQ_W-1:0] w_im_hw;
   logic [SW_IRQ_W-1:0] w_im_sw;
   logic                w_int_pend;
   logic                w_exc_valid;
   logic [4:0]          w_exc_code;

   logic [1:0]          r_state;
   state_e              w_state;
   state_e              w_state_d;
   logic                w_snap_en;
   logic                w_snap_int;
   logic [4:0]          w_code_d;

   logic [4:0]          r_code;
   logic                r_bd;
   logic [HW_IRQ_W-1:0] r_ip_h;
   logic [SW_IRQ_W-1:0] r_ip_s;
   logic                r_int;
   logic                r_epc;
   logic                w_commit;

`ifdef IRQ_SYNC_EN
   logic [HW_IRQ_W-1:0] r_ip_h_s1;
   logic [HW_IRQ_W-1:0] r_ip_h_s2;

   flopr #(.WIDTH(HW_IRQ_W)) u_sync1 (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (ip_h_in),
      .o_q   (r_ip_h_s1)
   );

   flopr #(.WIDTH(HW_IRQ_W)) u_sync2 (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (r_ip_h_s1),
      .o_q   (r_ip_h_s2)
   );

   assign w_ip_h = r_ip_h_s2;
`else
   assign w_ip_h = ip_h_in;
`endif

   assign w_im_hw    = int_mask[HW_IRQ_W+SW_IRQ_W-1:SW_IRQ_W];
   assign w_im_sw    = int_mask[SW_IRQ_W-1:0];
   assign w_int_pend = (|({w_ip_h, ip_s_in} & int_mask)) & int_en & ~exl;

   exc_prio_enc #(.EXC_W(EXC_W)) u_exc_prio_enc (
      .i_req   (exc_req),
      .o_valid (w_exc_valid),
      .o_code  (w_exc_code)
   );

   flopr #(.WIDTH(2), .RESET_VAL(StateRst)) u_state (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (w_state_d),
      .o_q   (r_state)
   );

   assign w_state = state_e'(r_state);

   // Requests are only sampled in IDLE and HANDLER; the flushed pipeline re-raises the rest.
   always_comb begin
      w_state_d  = w_state;
      w_snap_en  = 1'b0;
      w_snap_int = 1'b0;
      unique case (w_state)
         StIdle: begin
            if (w_exc_valid) begin
               w_state_d = StFlush;
               w_snap_en = 1'b1;
            end else if (w_int_pend) begin
               w_state_d  = StFlush;
               w_snap_en  = 1'b1;
               w_snap_int = 1'b1;
            end
         end
         StFlush: begin
            if (flush_ack) begin
               w_state_d = StCommit;
            end
         end
         StCommit: begin
            w_state_d = StHandler;
         end
         StHandler: begin
            if (w_exc_valid) begin
               w_state_d = StFlush;
               w_snap_en = 1'b1;
            end else if (eret) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign w_code_d = w_snap_int ? ExcInt : w_exc_code;

   flopren #(.WIDTH(5), .RESET_VAL(CodeRst)) u_code (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_snap_en),
      .i_d   (w_code_d),
      .o_q   (r_code)
   );

   flopren #(.WIDTH(1)) u_bd (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_snap_en),
      .i_d   (exc_bd),
      .o_q   (r_bd)
   );

   flopren #(.WIDTH(HW_IRQ_W)) u_ip_h (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_snap_en),
      .i_d   (w_ip_h),
      .o_q   (r_ip_h)
   );

   flopren #(.WIDTH(SW_IRQ_W)) u_ip_s (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_snap_en),
      .i_d   (ip_s_in),
      .o_q   (r_ip_s)
   );

   flopren #(.WIDTH(1)) u_int (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_snap_en),
      .i_d   (w_snap_int),
      .o_q   (r_int)
   );

   // EPC is only written when entering from user/kernel level, not from a nested handler.
   flopren #(.WIDTH(1)) u_epc (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_snap_en),
      .i_d   (~exl),
      .o_q   (r_epc)
   );

   assign w_commit        = (w_state == StCommit);
   assign flush_req       = (w_state == StFlush);
   assign busy            = (w_state != StIdle);
   assign exception_abort = w_commit;
   assign irq_h           = w_commit & r_int & (|(r_ip_h & w_im_hw));
   assign irq_s           = w_commit & r_int & (|(r_ip_s & w_im_sw));
   assign epc_we          = w_commit & r_epc;
   assign ip_h            = r_ip_h;
   assign ip_s            = r_ip_s;
   assign exception_code  = r_code;
   assign bd_p            = r_bd;

endmodule

// File: tb/tb_exception_arbiter.sv
// Self-checking bench for exception_arbiter: directed test-plan steps plus a randomized run
// checked every cycle against a behavioural model.
module tb_exception_arbiter;

   localparam int PhIdle    = 0;
   localparam int PhFlush   = 1;
   localparam int PhCommit  = 2;
   localparam int PhHandler = 3;

`ifdef IRQ_SYNC_EN
   localparam int SyncLat = 2;
`else
   localparam int SyncLat = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] exc_req;
   logic       exc_bd;
   logic [5:0] ip_h_in;
   logic [1:0] ip_s_in;
   logic [7:0] int_mask;
   logic       int_en;
   logic       exl;
   logic       eret;
   logic       flush_ack;
   logic       flush_req;
   logic       exception_abort;
   logic       irq_h;
   logic       irq_s;
   logic [5:0] ip_h;
   logic [1:0] ip_s;
   logic [4:0] exception_code;
   logic       bd_p;
   logic       epc_we;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   int         m_phase;
   logic [4:0] m_code;
   logic       m_bd;
   logic [5:0] m_iph;
   logic [1:0] m_ips;
   logic       m_int;
   logic       m_epc;
   logic [5:0] m_s1;
   logic [5:0] m_s2;
   int         code_tab[8] = '{4, 5, 8, 9, 10, 12, 13, 7};

   always #5 clk = ~clk;

   exception_arbiter u_dut (
      .clk             (clk),
      .rst             (rst),
      .exc_req         (exc_req),
      .exc_bd          (exc_bd),
      .ip_h_in         (ip_h_in),
      .ip_s_in         (ip_s_in),
      .int_mask        (int_mask),
      .int_en          (int_en),
      .exl             (exl),
      .eret            (eret),
      .flush_ack       (flush_ack),
      .flush_req       (flush_req),
      .exception_abort (exception_abort),
      .irq_h           (irq_h),
      .irq_s           (irq_s),
      .ip_h            (ip_h),
      .ip_s            (ip_s),
      .exception_code  (exception_code),
      .bd_p            (bd_p),
      .epc_we          (epc_we),
      .busy            (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic take(input logic is_irq, input logic [5:0] hw);
      int low;
      low = 0;
      for (int i = 7; i >= 0; i--) if (exc_req[i]) low = i;
      m_code = is_irq ? 5'd0 : 5'(code_tab[low]);
      m_bd   = exc_bd;
      m_iph  = hw;
      m_ips  = ip_s_in;
      m_int  = is_irq;
      m_epc  = ~exl;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      logic [5:0] hw;
      logic       pend;
      hw   = (SyncLat != 0) ? m_s2 : ip_h_in;
      pend = (|({hw, ip_s_in} & int_mask)) & int_en & ~exl;
      if (rst) begin
         m_phase = PhIdle;
         {m_code, m_bd, m_iph, m_ips, m_int, m_epc} = '0;
      end else begin
         case (m_phase)
            PhIdle: begin
               if (exc_req != 0) begin
                  take(1'b0, hw);
                  m_phase = PhFlush;
               end else if (pend) begin
                  take(1'b1, hw);
                  m_phase = PhFlush;
               end
            end
            PhFlush:  if (flush_ack) m_phase = PhCommit;
            PhCommit: m_phase = PhHandler;
            default: begin
               if (exc_req != 0) begin
                  take(1'b0, hw);
                  m_phase = PhFlush;
               end else if (eret) begin
                  m_phase = PhIdle;
               end
            end
         endcase
      end
      m_s2 = rst ? 6'd0 : m_s1;
      m_s1 = rst ? 6'd0 : ip_h_in;
   endtask

   task automatic check_all();
      logic c;
      c = (m_phase == PhCommit);
      chk("flush_req", 32'(flush_req), 32'(m_phase == PhFlush));
      chk("busy", 32'(busy), 32'(m_phase != PhIdle));
      chk("exception_abort", 32'(exception_abort), 32'(c));
      chk("irq_h", 32'(irq_h), 32'(c & m_int & (|(m_iph & int_mask[7:2]))));
      chk("irq_s", 32'(irq_s), 32'(c & m_int & (|(m_ips & int_mask[1:0]))));
      chk("epc_we", 32'(epc_we), 32'(c & m_epc));
      chk("exception_code", 32'(exception_code), 32'(m_code));
      chk("bd_p", 32'(bd_p), 32'(m_bd));
      chk("ip_h", 32'(ip_h), 32'(m_iph));
      chk("ip_s", 32'(ip_s), 32'(m_ips));
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      exc_req = '0; exc_bd = 0; ip_h_in = '0; ip_s_in = '0; int_mask = '0;
      int_en = 0; exl = 0; eret = 0; flush_ack = 0; rst = 0;
   endtask

   initial begin
      int flush_cnt;
      int lat;
      idle_inputs();
      m_phase = PhIdle;
      {m_code, m_bd, m_iph, m_ips, m_int, m_epc, m_s1, m_s2} = '0;

      // Reset
      rst = 1;
      cycle();
      cycle();
      rst = 0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_code", 32'(exception_code), 32'd0);

      // Exception with BD, ack after 3 flush cycles
      exc_req = 8'b0010_0100; exc_bd = 1; exl = 0;
      cycle();
      exc_req = '0; exc_bd = 0;
      flush_cnt = 0;
      if (flush_req) flush_cnt++;
      cycle();
      if (flush_req) flush_cnt++;
      cycle();
      if (flush_req) flush_cnt++;
      flush_ack = 1;
      cycle();
      flush_ack = 0;
      chk("t1_flush_cycles", 32'(flush_cnt), 32'd3);
      chk("t1_abort", 32'(exception_abort), 32'd1);
      chk("t1_code", 32'(exception_code), 32'd8);
      chk("t1_bd", 32'(bd_p), 32'd1);
      chk("t1_epc_we", 32'(epc_we), 32'd1);
      chk("t1_irq_h", 32'(irq_h), 32'd0);
      cycle();
      chk("t1_handler_abort_low", 32'(exception_abort), 32'd0);
      chk("t1_handler_busy", 32'(busy), 32'd1);
      eret = 1;
      cycle();
      eret = 0;
      chk("t1_eret_idle", 32'(busy), 32'd0);

      // Hardware interrupt
      ip_h_in = 6'b000100; int_mask = 8'b0001_0000; int_en = 1;
      for (int i = 0; i <= SyncLat; i++) cycle();
      flush_ack = 1;
      cycle();
      flush_ack = 0;
      chk("t2_abort", 32'(exception_abort), 32'd1);
      chk("t2_code", 32'(exception_code), 32'd0);
      chk("t2_irq_h", 32'(irq_h), 32'd1);
      chk("t2_irq_s", 32'(irq_s), 32'd0);
      chk("t2_ip_h", 32'(ip_h), 32'b000100);
      cycle();
      eret = 1; ip_h_in = '0;
      cycle();
      eret = 0;
      for (int i = 0; i < 3; i++) cycle();

      // Exception and interrupt in the same cycle; pending interrupt taken after ERET
      ip_h_in = 6'b000100; int_mask = 8'b0001_0000; int_en = 1;
      for (int i = 0; i < SyncLat; i++) begin
         exc_req = '0;
         cycle();
         cycle();
         eret = 1;
      end
      eret = 0;
      for (int i = 0; i < 2; i++) if (busy) begin eret = 1; cycle(); eret = 0; end
      exc_req = 8'b0010_0000;
      if (busy) begin exc_req = '0; end
      cycle();
      exc_req = '0;
      flush_ack = 1;
      cycle();
      flush_ack = 0;
      cycle();
      chk("t3_code", 32'(exception_code), 32'd12);
      chk("t3_irq_h", 32'(irq_h), 32'd0);
      eret = 1;
      cycle();
      eret = 0;
      cycle();
      chk("t3_irq_taken", 32'(flush_req), 32'd1);
      flush_ack = 1;
      cycle();
      flush_ack = 0;
      chk("t3_irq_code", 32'(exception_code), 32'd0);
      chk("t3_irq_h_commit", 32'(irq_h), 32'd1);
      cycle();

      // In handler with EXL set: interrupts ignored, nested exception, ERET
      exl = 1;
      cycle();
      chk("t4_irq_ignored", 32'(busy), 32'd1);
      exc_req = 8'b0000_0001;
      cycle();
      exc_req = '0; flush_ack = 1;
      cycle();
      flush_ack = 0;
      chk("t4_code", 32'(exception_code), 32'd4);
      chk("t4_epc_we", 32'(epc_we), 32'd0);
      cycle();
      eret = 1;
      cycle();
      eret = 0;
      chk("t4_idle", 32'(busy), 32'd0);
      ip_h_in = '0; exl = 0; int_en = 0;
      cycle();
      cycle();

      // Reset during FLUSH drops the in-flight event
      exc_req = 8'b1000_0000;
      cycle();
      exc_req = '0;
      chk("t5_in_flush", 32'(flush_req), 32'd1);
      rst = 1; flush_ack = 1;
      cycle();
      rst = 0; flush_ack = 0;
      chk("t5_code_cleared", 32'(exception_code), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) cycle();

      // Interrupt latency from a single ip_h_in rise
      int_en = 1; int_mask = 8'hFC; ip_h_in = 6'b100000;
      lat = 0;
      for (int i = 0; i < 10 && !flush_req; i++) begin
         cycle();
         lat++;
      end
      chk("t6_irq_latency", 32'(lat), 32'(1 + SyncLat));
      flush_ack = 1;
      cycle();
      cycle();
      flush_ack = 0; ip_h_in = '0; eret = 1;
      cycle();
      eret = 0;

      // Randomized run against the model
      for (int n = 0; n < 600; n++) begin
         exc_req   = ($urandom_range(0, 6) == 0) ? 8'($urandom) : 8'd0;
         exc_bd    = 1'($urandom);
         ip_h_in   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
         ip_s_in   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd0;
         int_mask  = 8'($urandom);
         int_en    = 1'($urandom);
         exl       = ($urandom_range(0, 2) == 0);
         eret      = ($urandom_range(0, 4) == 0);
         flush_ack = ($urandom_range(0, 2) == 0);
         rst       = ($urandom_range(0, 59) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
